mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency memory between IF (instruction read) and MEM (data read/write).

---
 rtl/arb_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the IF/MEM memory port arbiter
package arb_pkg;

  // Access sequencing: arbitrate, hold the backing-memory bus, then answer the owner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } owner_t;

  // Byte addresses are word aligned; the backing memory sees word addresses.
  localparam int BYTE_OFF_W = 2;
  localparam int DATA_W     = 32;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - load/decrement/done counter timing one backing-memory access
module mem_wait_timer #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on grant, count down while busy, hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for one fixed-latency memory (optional ARB_STARVE_GUARD_EN)
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int WAIT_CYCLES  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_r_en_i,
  input  logic              mem_w_en_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_ready_o,
  output logic              freeze_o,
  output logic              ext_en_o,
  output logic              ext_we_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  output logic [31:0]       ext_wdata_o,
  input  logic [31:0]       ext_rdata_i
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic mem_req;
  logic force_if;
  logic grant_mem;
  logic grant_if;
  logic timer_load;
  logic timer_dec;
  logic timer_done;

  assign mem_req = mem_r_en_i | mem_w_en_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_if = if_req_i && (starve_q == STARVE_W'(STARVE_LIMIT));

  // Count back-to-back MEM wins that left IF waiting; any IF win clears it.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req_i && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic starve_limit_unused;
  assign starve_limit_unused = ^STARVE_LIMIT;
  assign force_if = 1'b0;
`endif

  // IDLE grant decision: MEM wins unless the starvation guard hands this slot to IF.
  always_comb begin
    grant_mem = (state_q == IDLE) && mem_req && !force_if;
    grant_if  = (state_q == IDLE) && if_req_i && !grant_mem;
  end

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(timer_load),
    .dec_i (timer_dec),
    .done_o(timer_done)
  );

  // Access FSM: latch the winner, hold the bus for the wait window, answer once.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          owner_d    = GNT_MEM;
          we_d       = mem_w_en_i;
          addr_d     = mem_addr_i;
          wdata_d    = mem_wdata_i;
          timer_load = 1'b1;
          state_d    = BUSY;
        end else if (grant_if) begin
          owner_d    = GNT_IF;
          we_d       = 1'b0;
          addr_d     = if_addr_i;
          timer_load = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        timer_dec = 1'b1;
        if (timer_done) begin
          if (owner_q == GNT_IF) begin
            if_rdata_d = ext_rdata_i;
          end else if (!we_q) begin
            mem_rdata_d = ext_rdata_i;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= GNT_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // An IF answer is dropped if the fetch was withdrawn or redirected meanwhile.
  assign if_ready_o  = (state_q == RESP) && (owner_q == GNT_IF) &&
                       if_req_i && (if_addr_i == addr_q);
  assign mem_ready_o = (state_q == RESP) && (owner_q == GNT_MEM);
  assign freeze_o    = mem_req & ~mem_ready_o;

  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ext_en_o    = (state_q == BUSY);
  assign ext_we_o    = (state_q == BUSY) && we_q;
  assign ext_addr_o  = addr_q[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign ext_wdata_o = wdata_q;

endmodule
